// File: rtl/speck_pkg.sv
// Shared definitions for the SPECK datapath blocks: default word width,
// serial-adder controller state encoding and counter sizing helper.
package speck_pkg;

    // SPECK32/64 word width.
    localparam int WORD_W_DEFAULT = 16;

    // Serial add/sub controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_t;

    // Width of a counter that must index bit positions 0..w-1.
    // $clog2(w) is already >= 1 for every legal w (2..64), but the guard
    // keeps a degenerate w from producing a zero-width counter.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage : speck_pkg

// File: rtl/speck_serial_add_ctrl_adder.sv
// AOIG_Adder: one-bit full-adder cell built as the classic mirror adder out of
// AND-OR-INVERT stages. The carry is formed first (inverted), and the sum reuses
// the inverted carry, so the cell has two AOI levels on the sum path.
module AOIG_Adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    logic cout_n;
    logic sum_n;

    // Majority function as AOI: cout_n = ~(A&B | Cin&(A|B)).
    always_comb begin
        cout_n = ~((A & B) | (Cin & (A | B)));
    end

    // Sum as AOI: sum_n = ~((A|B|Cin)&cout_n | A&B&Cin).
    // Odd parity is "at least one input set but not a majority", or all three set.
    always_comb begin
        sum_n = ~(((A | B | Cin) & cout_n) | (A & B & Cin));
    end

    // Output inverters restore true polarity.
    always_comb begin
        Sum  = ~sum_n;
        Cout = ~cout_n;
    end

endmodule : AOIG_Adder

// File: rtl/speck_serial_add_ctrl.sv
// speck_serial_add_ctrl: bit-serial SPECK modular adder/subtractor.
// Accepts two WORD_W operands via valid/ready, feeds them LSB first through a
// single AOIG_Adder cell over WORD_W cycles, then presents the sum (or a - b)
// and the final carry until the consumer takes it.
module speck_serial_add_ctrl
    import speck_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] result,
    output logic              carry_out
);

    localparam int CNT_W = cnt_width(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    add_state_t        state_q;
    logic [WORD_W-1:0] a_sr;
    logic [WORD_W-1:0] b_sr;
    logic [WORD_W-1:0] res_sr;
    logic [CNT_W-1:0]  cnt_q;
    logic              carry_q;
    logic              cout_q;

    logic              cell_sum;
    logic              cell_cout;
    logic              last_bit;

    // The one physical adder cell; operands are presented LSB first.
    AOIG_Adder u_cell (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (carry_q),
        .Sum  (cell_sum),
        .Cout (cell_cout)
    );

    // Final bit of the word is being added this cycle.
    always_comb begin
        last_bit = (cnt_q == LAST_BIT);
    end

    // Sequencer: load operands, shift WORD_W bits through the cell, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert b and seed the carry.
                        a_sr    <= a;
                        b_sr    <= sub ? ~b : b;
                        carry_q <= sub;
                        res_sr  <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so after WORD_W shifts bit 0 lands at [0].
                    res_sr  <= {cell_sum, res_sr[WORD_W-1:1]};
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry_q <= cell_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // Carry out of the MSB is reported, never fed back (mod 2^WORD_W).
                        cout_q  <= cell_cout;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Result stays put until the consumer takes it.
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags are pure state decodes: no same-cycle handoff and accept.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        result    = res_sr;
        carry_out = cout_q;
    end

endmodule : speck_serial_add_ctrl

// File: tb/tb_speck_serial_add_ctrl.sv
// Self-checking bench for speck_serial_add_ctrl (WORD_W = 16).
// Directed cases followed by a randomized regression against an arithmetic model.
module tb_speck_serial_add_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;

    int compared;
    int mismatched;

    speck_serial_add_ctrl #(.WORD_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain modular arithmetic on integers.
    function automatic logic [W-1:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int unsigned r;
        r = s ? (int'(x) - int'(y)) : (int'(x) + int'(y));
        return r[W-1:0];
    endfunction

    // Add: carry when the true sum reaches 2^W. Subtract: carry means no borrow (x >= y).
    function automatic logic ref_carry(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        if (s) return (x >= y);
        return ((int'(x) + int'(y)) >= (1 << W));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Directed op: accept at the next posedge, scramble inputs afterwards,
    // measure latency, hold out_ready low for 'hold' cycles, then release.
    task automatic op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                      input int hold, input logic junk, input string tag);
        int n;
        logic [W-1:0] er;
        logic         ec;
        er = ref_res(ai, bi, si);
        ec = ref_carry(ai, bi, si);
        chk({tag, " in_ready idle"}, in_ready, 1);
        in_valid = 1'b1; a = ai; b = bi; sub = si; out_ready = 1'b0;
        @(negedge clk);
        // Post-accept input activity must be ignored.
        in_valid = junk; a = junk ? 16'hAAAA : W'($urandom); b = W'($urandom); sub = 1'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, W);
        chk({tag, " result"}, result, er);
        chk({tag, " carry"}, carry_out, ec);
        chk({tag, " in_ready busy"}, in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, out_valid, 1);
            chk({tag, " hold result"}, {in_ready, carry_out, result}, {1'b0, ec, er});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " valid drop"}, out_valid, 0);
    endtask

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         qs[$];

    initial begin
        int done_ops;
        int cyc;
        logic checked;
        compared = 0; mismatched = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset state", {in_ready, out_valid, carry_out, result}, {1'b1, 1'b0, 1'b0, 16'h0000});
        rst = 1'b0;
        @(negedge clk);

        op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, "add");
        op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "wrap1");
        op(16'h8000, 16'h8000, 1'b0, 0, 1'b0, "wrap2");
        op(16'h0000, 16'h0001, 1'b1, 0, 1'b0, "sub_borrow");
        op(16'h5555, 16'h5555, 1'b1, 0, 1'b0, "sub_equal");
        op(16'h00FF, 16'h0101, 1'b0, 10, 1'b1, "backpressure");
        op(16'h1111, 16'h2222, 1'b0, 0, 1'b0, "after_bp");

        // Reset in the middle of RUN: everything returns to reset values.
        in_valid = 1'b1; a = 16'h1234; b = 16'h1111; sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset state", {in_ready, out_valid, carry_out, result}, {1'b1, 1'b0, 1'b0, 16'h0000});
        begin
            logic seen;
            seen = 1'b0;
            repeat (20) begin
                @(negedge clk);
                seen = seen | out_valid;
            end
            chk("midreset no out_valid", seen, 0);
        end
        op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0, "post_reset");

        // Random regression: in_valid always high with fresh operands, random out_ready.
        done_ops = 0; cyc = 0; checked = 1'b0;
        in_valid = 1'b1;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        while (done_ops < 1000 && cyc < 60000) begin
            // Inputs for the coming posedge are stable here; state-decoded flags too.
            if (in_ready) begin
                qa.push_back(a); qb.push_back(b); qs.push_back(sub);
            end
            if (out_valid) begin
                if (!checked) begin
                    if (qa.size() == 0) begin
                        chk("rand unexpected result", 1, 0);
                    end else begin
                        chk("rand result", result, ref_res(qa[0], qb[0], qs[0]));
                        chk("rand carry", carry_out, ref_carry(qa[0], qb[0], qs[0]));
                    end
                    checked = 1'b1;
                end
                out_ready = ($urandom_range(0, 2) == 0);
                if (out_ready) begin
                    if (qa.size() != 0) begin
                        void'(qa.pop_front()); void'(qb.pop_front()); void'(qs.pop_front());
                    end
                    done_ops++;
                    checked = 1'b0;
                end
            end else begin
                out_ready = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        end
        chk("rand ops completed", done_ops, 1000);
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_speck_serial_add_ctrl
